// File: rtl/quad_gen.sv
// quad_gen: quadrature signal generator (transmit side of the rotary-encoder path).
//
// Accepts step commands over a valid/ready handshake and drives the A/B
// quadrature lines, holding each phase for a programmable number of clocks.
// When bounce is enabled, the line that changes in each phase glitches
// between its new and old values for a few clocks before settling.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   cmd_valid  command request
//   cmd_ready  command accept (= ~busy)
//   cmd_dir    1 = increment (A leads B), 0 = decrement (B leads A)
//   cmd_steps  number of full quadrature cycles to emit (0 = no-op)
//   period     clocks per phase (0 treated as 1)
//   bounce_en  inject contact bounce on every edge
//   a, b       quadrature outputs (registered)
//   busy       command in progress (registered)
//   position   wrapping signed count of completed steps (registered)

module quad_gen #(
  parameter int width      = 8,
  parameter int div_width  = 16,
  parameter int bounce_len = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_dir,
  input  logic [width-1:0]     cmd_steps,
  input  logic [div_width-1:0] period,
  input  logic                 bounce_en,
  output logic                 a,
  output logic                 b,
  output logic                 busy,
  output logic [width-1:0]     position
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  // Number of clocks at the start of a phase that may carry bounce glitches
  // (one extra bit so a large bounce_len cannot wrap the comparison).
  localparam logic [div_width:0] glitch_clks = (div_width+1)'(2 * bounce_len);

  state_t               state, state_nx;
  logic                 dir_q, dir_nx;
  logic                 bounce_q, bounce_nx;
  logic [width-1:0]     steps_q, steps_nx;
  logic [width-1:0]     pos_q, pos_nx;
  logic [div_width-1:0] period_q, period_nx;
  logic [div_width-1:0] cnt_q, cnt_nx;
  logic [div_width-1:0] cnt_inc;
  logic [1:0]           phase_q, phase_nx;
  logic [1:0]           ab_q, ab_nx;
  logic                 phase_end;

  // Settled {a,b} at the end of a given phase index. Index 3 is always the
  // 00 rest state, so "previous phase" of index 0 is index 3.
  function automatic logic [1:0] settled_ab(input logic dir, input logic [1:0] idx);
    logic [1:0] r;
    case (idx)
      2'd0:    r = dir ? 2'b10 : 2'b01;
      2'd1:    r = 2'b11;
      2'd2:    r = dir ? 2'b01 : 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  assign cnt_inc   = cnt_q + div_width'(1);
  assign phase_end = (cnt_q == period_q - div_width'(1));

  // Next-state logic. Outputs are registered, so the value the lines show in
  // the next clock is computed here from the next phase/count. A glitch clock
  // shows the previous phase's settled value; since adjacent phases differ in
  // one line only, only the changing line bounces. The last clock of a phase
  // is excluded from glitching so it always shows the settled value.
  always_comb begin
    state_nx  = state;
    dir_nx    = dir_q;
    bounce_nx = bounce_q;
    steps_nx  = steps_q;
    pos_nx    = pos_q;
    period_nx = period_q;
    cnt_nx    = cnt_q;
    phase_nx  = phase_q;
    ab_nx     = ab_q;
    case (state)
      IDLE: begin
        if (cmd_valid && (cmd_steps != '0)) begin
          state_nx  = RUN;
          dir_nx    = cmd_dir;
          bounce_nx = bounce_en;
          steps_nx  = cmd_steps;
          period_nx = (period == '0) ? div_width'(1) : period;
          cnt_nx    = '0;
          phase_nx  = 2'd0;
          ab_nx     = settled_ab(cmd_dir, 2'd0);
        end
      end
      RUN: begin
        if (phase_end) begin
          cnt_nx = '0;
          if (phase_q == 2'd3) begin
            pos_nx   = dir_q ? (pos_q + width'(1)) : (pos_q - width'(1));
            steps_nx = steps_q - width'(1);
            phase_nx = 2'd0;
            if (steps_q == width'(1)) begin
              state_nx = IDLE;
              ab_nx    = 2'b00;
            end else begin
              ab_nx = settled_ab(dir_q, 2'd0);
            end
          end else begin
            phase_nx = phase_q + 2'd1;
            ab_nx    = settled_ab(dir_q, phase_q + 2'd1);
          end
        end else begin
          cnt_nx = cnt_inc;
          if (bounce_q && cnt_inc[0] && ({1'b0, cnt_inc} < glitch_clks) &&
              (cnt_inc < period_q - div_width'(1)))
            ab_nx = settled_ab(dir_q, phase_q - 2'd1);
          else
            ab_nx = settled_ab(dir_q, phase_q);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset forces the lines to rest and clears position
  // immediately, even mid-command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      dir_q    <= 1'b0;
      bounce_q <= 1'b0;
      steps_q  <= '0;
      pos_q    <= '0;
      period_q <= div_width'(1);
      cnt_q    <= '0;
      phase_q  <= 2'd0;
      ab_q     <= 2'b00;
    end else begin
      state    <= state_nx;
      dir_q    <= dir_nx;
      bounce_q <= bounce_nx;
      steps_q  <= steps_nx;
      pos_q    <= pos_nx;
      period_q <= period_nx;
      cnt_q    <= cnt_nx;
      phase_q  <= phase_nx;
      ab_q     <= ab_nx;
    end
  end

  assign busy      = (state == RUN);
  assign cmd_ready = ~busy;
  assign a         = ab_q[1];
  assign b         = ab_q[0];
  assign position  = pos_q;

endmodule

// File: tb/tb_quad_gen.sv
// tb_quad_gen: self-checking bench for quad_gen.
//
// Drives directed commands, logs the A/B lines each clock while busy, and
// compares against hand-computed patterns. A small quadrature decoder model
// watches the lines to confirm the net edge count matches the commanded steps.

module tb_quad_gen;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [7:0]  cmd_steps;
  logic [15:0] period;
  logic        bounce_en;
  logic        a;
  logic        b;
  logic        busy;
  logic [7:0]  position;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0] ab_log[$];
  logic [7:0] pos_log[$];
  int         busy_cycles;

  int         quad_count  = 0;
  int         illegal_cnt = 0;
  int         accept_cnt  = 0;
  logic [1:0] prev_ab     = 2'b00;

  quad_gen #(.width(8), .div_width(16), .bounce_len(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .period    (period),
    .bounce_en (bounce_en),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .position  (position)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gray-code decoder model: sampled shortly after each rising edge.
  always @(posedge clk) begin
    int idx_old;
    int idx_new;
    int diff;
    #2;
    if ({a, b} !== prev_ab) begin
      idx_old = (prev_ab == 2'b00) ? 0 : (prev_ab == 2'b10) ? 1 : (prev_ab == 2'b11) ? 2 : 3;
      idx_new = ({a, b} == 2'b00) ? 0 : ({a, b} == 2'b10) ? 1 : ({a, b} == 2'b11) ? 2 : 3;
      diff = (idx_new - idx_old + 4) % 4;
      if (diff == 1) quad_count++;
      else if (diff == 3) quad_count--;
      else illegal_cnt++;
      prev_ab = {a, b};
    end
  end

  // Handshake monitor: counts edges where a command is offered and accepted.
  always @(posedge clk) begin
    if (reset && cmd_valid && cmd_ready) accept_cnt++;
  end

  // Safety net against a hung DUT.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, $signed(actual), $signed(expected));
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    cmd_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Offer one command for one edge, then scramble the inputs and log the
  // lines every clock while busy. Returns at the negedge of the first idle clock.
  task automatic applyStimulus(input logic dir, input logic [7:0] steps,
                               input logic [15:0] per, input logic bnc);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = steps;
    period    = per;
    bounce_en = bnc;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_dir   = ~dir;
    cmd_steps = 8'hA5;
    period    = 16'd7;
    bounce_en = ~bnc;
    ab_log.delete();
    pos_log.delete();
    busy_cycles = 0;
    while (busy && busy_cycles < 5000) begin
      ab_log.push_back({a, b});
      pos_log.push_back(position);
      busy_cycles++;
      @(negedge clk);
    end
    if (busy) checkOutput("busy_timeout", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic        dir;
    logic [7:0]  steps;
    logic [15:0] per;
    logic        bnc;
    int          exp_busy;
    logic [7:0]  exp_pos;
    int          exp_quad;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [1:0] inc_phase[4];
    logic [1:0] dec_phase[4];
    logic [1:0] bnc8[32];
    logic [1:0] bnc2[8];
    int q0;
    int ill0;
    int acc0;
    int n;
    logic [7:0] pos0;

    inc_phase = '{2'b10, 2'b11, 2'b01, 2'b00};
    dec_phase = '{2'b01, 2'b11, 2'b10, 2'b00};
    bnc8 = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2,
             2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3,
             2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1,
             2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
    bnc2 = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd0, 2'd0};

    vecs[0] = '{1'b1, 8'd2, 16'd3, 1'b0, 24, 8'd2,   8};
    vecs[1] = '{1'b0, 8'd1, 16'd0, 1'b0,  4, 8'd1,  -4};
    vecs[2] = '{1'b0, 8'd3, 16'd1, 1'b1, 12, 8'd254, -12};
    vecs[3] = '{1'b1, 8'd1, 16'd5, 1'b1, 20, 8'd255,  4};
    vecs[4] = '{1'b1, 8'd2, 16'd2, 1'b0, 16, 8'd1,    8};
    vecs[5] = '{1'b1, 8'd0, 16'd4, 1'b1,  0, 8'd1,    0};

    // Reset held with a command offered: nothing may start.
    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = 8'd1;
    period    = 16'd1;
    bounce_en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_a", 32'(a), 32'd0);
    checkOutput("reset_b", 32'(b), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_position", 32'(position), 32'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);

    // Decrement with wrap, period 0 treated as 1.
    doReset();
    applyStimulus(1'b0, 8'd1, 16'd0, 1'b0);
    checkOutput("dec_busy_cycles", 32'(busy_cycles), 32'd4);
    for (int i = 0; i < 4 && i < ab_log.size(); i++)
      checkOutput($sformatf("dec_ab[%0d]", i), 32'(ab_log[i]), 32'(dec_phase[i]));
    checkOutput("dec_position", 32'(position), 32'd255);
    checkOutput("dec_rest_ab", 32'({a, b}), 32'd0);

    // Increment, two steps, three clocks per phase.
    doReset();
    applyStimulus(1'b1, 8'd2, 16'd3, 1'b0);
    checkOutput("inc_busy_cycles", 32'(busy_cycles), 32'd24);
    for (int i = 0; i < 24 && i < ab_log.size(); i++)
      checkOutput($sformatf("inc_ab[%0d]", i), 32'(ab_log[i]), 32'(inc_phase[(i / 3) % 4]));
    if (pos_log.size() > 12) begin
      checkOutput("inc_pos_step1", 32'(pos_log[11]), 32'd0);
      checkOutput("inc_pos_step2", 32'(pos_log[12]), 32'd1);
    end
    checkOutput("inc_position", 32'(position), 32'd2);
    checkOutput("inc_rest_ab", 32'({a, b}), 32'd0);

    // Bounce with period 8: four glitch clocks then settled.
    doReset();
    applyStimulus(1'b1, 8'd1, 16'd8, 1'b1);
    checkOutput("bnc8_busy_cycles", 32'(busy_cycles), 32'd32);
    for (int i = 0; i < 32 && i < ab_log.size(); i++)
      checkOutput($sformatf("bnc8_ab[%0d]", i), 32'(ab_log[i]), 32'(bnc8[i]));

    // Bounce with period 2: glitches clipped away entirely.
    applyStimulus(1'b1, 8'd1, 16'd2, 1'b1);
    checkOutput("bnc2_busy_cycles", 32'(busy_cycles), 32'd8);
    for (int i = 0; i < 8 && i < ab_log.size(); i++)
      checkOutput($sformatf("bnc2_ab[%0d]", i), 32'(ab_log[i]), 32'(bnc2[i]));

    // Handshake: valid held through a three-step command.
    doReset();
    acc0      = accept_cnt;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = 8'd3;
    period    = 16'd1;
    bounce_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput("hs_busy_cycles", 32'(n), 32'd12);
    checkOutput("hs_single_accept", 32'(accept_cnt - acc0), 32'd1);
    checkOutput("hs_gap_ab", 32'({a, b}), 32'd0);
    checkOutput("hs_gap_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("hs_second_accept", 32'(accept_cnt - acc0), 32'd2);
    checkOutput("hs_second_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput("hs_second_done", 32'(busy), 32'd0);

    // Zero-step command: handshake completes, nothing else happens.
    pos0      = position;
    acc0      = accept_cnt;
    cmd_valid = 1'b1;
    cmd_steps = 8'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("zero_accept", 32'(accept_cnt - acc0), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    checkOutput("zero_ready", 32'(cmd_ready), 32'd1);
    checkOutput("zero_ab", 32'({a, b}), 32'd0);
    checkOutput("zero_position", 32'(position), 32'(pos0));

    // Mid-command reset during phase 2 of step 2.
    doReset();
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = 8'd3;
    period    = 16'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (13) @(negedge clk);
    checkOutput("mid_pre_ab", 32'({a, b}), 32'd1);
    checkOutput("mid_pre_position", 32'(position), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_a", 32'(a), 32'd0);
    checkOutput("mid_reset_b", 32'(b), 32'd0);
    checkOutput("mid_reset_busy", 32'(busy), 32'd0);
    checkOutput("mid_reset_ready", 32'(cmd_ready), 32'd1);
    checkOutput("mid_reset_position", 32'(position), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 8'd1, 16'd1, 1'b0);
    checkOutput("mid_after_busy", 32'(busy_cycles), 32'd4);
    for (int i = 0; i < 4 && i < ab_log.size(); i++)
      checkOutput($sformatf("mid_after_ab[%0d]", i), 32'(ab_log[i]), 32'(inc_phase[i]));
    checkOutput("mid_after_position", 32'(position), 32'd1);

    // Table of commands, run back to back from a fresh reset.
    doReset();
    for (int v = 0; v < 6; v++) begin
      q0 = quad_count;
      applyStimulus(vecs[v].dir, vecs[v].steps, vecs[v].per, vecs[v].bnc);
      checkOutput($sformatf("vec%0d_busy", v), 32'(busy_cycles), 32'(vecs[v].exp_busy));
      checkOutput($sformatf("vec%0d_position", v), 32'(position), 32'(vecs[v].exp_pos));
      checkOutput($sformatf("vec%0d_rest_ab", v), 32'({a, b}), 32'd0);
      checkOutput($sformatf("vec%0d_quad_delta", v), 32'(quad_count - q0), 32'(vecs[v].exp_quad));
    end

    // Loopback-style run: decoder must track position through bounce.
    doReset();
    q0   = quad_count;
    ill0 = illegal_cnt;
    applyStimulus(1'b1, 8'd37, 16'd20, 1'b1);
    checkOutput("loop_up_busy", 32'(busy_cycles), 32'd2960);
    checkOutput("loop_up_position", 32'(position), 32'd37);
    checkOutput("loop_up_decoder", 32'((quad_count - q0) / 4), 32'd37);
    applyStimulus(1'b0, 8'd37, 16'd20, 1'b1);
    checkOutput("loop_down_position", 32'(position), 32'd0);
    checkOutput("loop_down_decoder", 32'((quad_count - q0) / 4), 32'd0);
    checkOutput("loop_illegal_edges", 32'(illegal_cnt - ill0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/quad_gen.md
# quad_gen

Quadrature signal generator: accepts step commands over a valid/ready handshake and drives A/B quadrature outputs at a programmable phase period, optionally injecting contact bounce on every edge. It is the transmit side of the rotary-encoder path: it emulates a physical encoder for on-chip self-test and loopback into the existing debounce → encoder → pwm chain, and drives external quadrature inputs (e.g. motor drivers).

## Interface

Parameters:
- width, 8: width of cmd_steps and position.
- div_width, 16: width of period and the phase counter.
- bounce_len, 2: number of glitch pairs injected per edge when bounce is enabled.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accept, equal to ~busy.
- cmd_dir  input  1  1 = increment (A leads B), 0 = decrement (B leads A).
- cmd_steps  input  width  number of full quadrature cycles to emit.
- period  input  div_width  clocks per phase; 0 is treated as 1.
- bounce_en  input  1  enable bounce injection.
- a  output  1  quadrature channel A.
- b  output  1  quadrature channel B.
- busy  output  1  command in progress.
- position  output  width  wrapping signed count of completed steps.

## Operation

- One step = one full quadrature cycle = 4 phase transitions. Increment (A,B): 00→10→11→01→00. Decrement: 00→01→11→10→00. Between commands the outputs always rest at 00.
- FSM:
  - IDLE: busy=0. On cmd_valid && cmd_ready with cmd_steps≠0, latch dir, steps, period (0→1) and bounce_en, then go to RUN at phase index 0.
  - RUN: each phase holds for period clocks. At phase end, advance the phase index (mod 4). When index 3 ends, position ±1 (wrap mod 2^width) and the step counter decrements. When the last step completes, go to IDLE.
- cmd_steps==0: handshake completes, nothing latched, no output change, busy stays 0.
- cmd_valid while busy is ignored, and nothing is queued. Inputs changed during RUN have no effect.
- Bounce (latched bounce_en=1): only the line changing in the current phase bounces. For the first min(2·bounce_len, period−1) clocks of the phase it alternates new, old, new, old… one value per clock. It then holds the new value for the rest of the phase. The last clock of every phase always shows the settled value. The non-changing line never glitches.
- Reset asserted, at any time including mid-command: a=0, b=0, busy=0, cmd_ready=1, position=0, FSM=IDLE. No handshake completes while reset is low.

## Timing

- All outputs are registered except cmd_ready (= ~busy).
- Command accepted on edge N: at N+1 busy=1 and (a,b) shows phase-0 state (or its first bounce value).
- A command of S steps and period P keeps busy=1 for exactly 4·S·P clocks, from N+1 through N+4·S·P. The next edge returns busy=0 with (a,b)=00. A new command can be accepted on that edge.
- position updates on the same edge the 00 state (end of phase index 3) is left. That is the edge where phase index 0 of the next step starts, or where the FSM goes to IDLE.
- Phase counter and step counter use full-width arithmetic with no overflow. Maximum period is 2^div_width−1 and maximum steps is 2^width−1.

## Test plan

- Reset: hold reset low, drive cmd_valid=1 → a=b=0, busy=0, cmd_ready=1, position=0. After release, no command has been taken.
- Increment: dir=1, steps=2, period=3, bounce off, position 0 → AB = 10,11,01,00,10,11,01,00, each for 3 clocks; busy high 24 clocks; position 1 then 2; AB=00 afterwards.
- Decrement with wrap: dir=0, steps=1, period=0 from position 0 → AB = 01,11,10,00 one clock each; busy 4 clocks; position=255 (width=8).
- Bounce: bounce_len=2, period=8, dir=1, steps=1 → in phase 0, A = 1,0,1,0 then 1 for 4 clocks while B stays 0. Same pattern on B in phase 1. Repeat with period=2 → A = 1,1 (bounce clipped to zero glitches).
- Handshake: cmd_valid held during a steps=3 command → exactly one acceptance; the second accepts on the cycle busy falls. A steps=0 command → cmd_ready stays 1, AB unchanged, position unchanged.
- Mid-command reset: assert reset during phase 2 of step 2 → a=b=0, busy=0, position=0 without waiting for a clock edge. A new command after release runs from phase 0.
- Loopback: outputs → debounce (hist_len 8) → encoder (width 8), bounce on, period=20, ±37 steps → decoder value tracks position at command end.
